// File: rtl/apb_wdt_gen.sv
// APB watchdog with internal prescaler and down-counter, windowed keyed kick,
// configuration lock key and two-stage (interrupt, then reset request) timeout.
module apb_wdt_gen #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRE_W      = 16,
    parameter logic [31:0] KICK_KEY   = 32'h5A5AA5A5,
    parameter logic [31:0] UNLOCK_KEY = 32'h1ACCE551
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [19:2] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    output logic        WDRST,
    output logic        WDRUN
);

    localparam logic [17:0] A_CNT    = 18'h000;
    localparam logic [17:0] A_LOAD   = 18'h001;
    localparam logic [17:0] A_WIN    = 18'h002;
    localparam logic [17:0] A_STATUS = 18'h003;
    localparam logic [17:0] A_CLR    = 18'h004;
    localparam logic [17:0] A_CTRL   = 18'h005;
    localparam logic [17:0] A_PRESC  = 18'h006;
    localparam logic [17:0] A_KICK   = 18'h007;
    localparam logic [17:0] A_LOCK   = 18'h008;
    localparam logic [17:0] A_IRQEN  = 18'h040;

    logic [WIDTH-1:0] cnt, load, win;
    logic [PRE_W-1:0] pcnt, presc;
    logic             en, winen, rsten;
    logic             ov, rstreq, early, locked;
    logic [1:0]       irqen;
    logic             wdrst_q;

    logic       wr, wr_cfg;
    logic       tick, kick, in_win, kick_ok, kick_early, en_rise;
    logic       expire, exp1, exp2;
    logic [2:0] clr;

    always_comb begin
        wr         = PSEL & PWRITE & PENABLE;
        wr_cfg     = wr & ~locked;
        tick       = en & (pcnt == presc);
        kick       = wr & (PADDR == A_KICK) & (PWDATA == KICK_KEY) & en;
        in_win     = ~winen | (cnt <= win);
        kick_ok    = kick & in_win;
        kick_early = kick & ~in_win;
        en_rise    = wr_cfg & (PADDR == A_CTRL) & PWDATA[0] & ~en;
        // A reloading kick takes the cycle; an early kick leaves the tick alone.
        expire     = tick & ~kick_ok & (cnt == '0);
        exp1       = expire & ~ov;
        exp2       = expire & ov;
        clr        = (wr && PADDR == A_CLR) ? PWDATA[2:0] : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt  <= '0;
            pcnt <= '0;
        end else if (en_rise || kick_ok) begin
            cnt  <= load;
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PRE_W'(1);
            if (tick)
                cnt <= (cnt == '0) ? load : cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ov      <= 1'b0;
            rstreq  <= 1'b0;
            early   <= 1'b0;
            wdrst_q <= 1'b0;
        end else begin
            ov      <= exp1 | (ov & ~clr[0]);
            rstreq  <= exp2 | kick_early | (rstreq & ~clr[1]);
            early   <= kick_early | (early & ~clr[2]);
            wdrst_q <= rsten & (exp2 | kick_early);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            load   <= '0;
            win    <= '0;
            presc  <= '0;
            en     <= 1'b0;
            winen  <= 1'b0;
            rsten  <= 1'b0;
            locked <= 1'b0;
            irqen  <= '0;
        end else if (wr) begin
            if (wr_cfg && PADDR == A_LOAD)
                load <= PWDATA[WIDTH-1:0];
            if (wr_cfg && PADDR == A_WIN)
                win <= PWDATA[WIDTH-1:0];
            if (wr_cfg && PADDR == A_PRESC)
                presc <= PWDATA[PRE_W-1:0];
            if (wr_cfg && PADDR == A_CTRL) begin
                en    <= PWDATA[0];
                winen <= PWDATA[1];
                rsten <= PWDATA[2];
            end
            if (PADDR == A_LOCK)
                locked <= (PWDATA != UNLOCK_KEY);
            if (PADDR == A_IRQEN)
                irqen <= PWDATA[1:0];
        end
    end

    always_comb begin
        PRDATA = 32'hDEADBEEF;
        case (PADDR)
            A_CNT:    PRDATA = 32'(cnt);
            A_LOAD:   PRDATA = 32'(load);
            A_WIN:    PRDATA = 32'(win);
            A_STATUS: PRDATA = {28'd0, locked, early, rstreq, ov};
            A_CLR:    PRDATA = '0;
            A_CTRL:   PRDATA = {29'd0, rsten, winen, en};
            A_PRESC:  PRDATA = 32'(presc);
            A_KICK:   PRDATA = '0;
            A_LOCK:   PRDATA = {31'd0, locked};
            A_IRQEN:  PRDATA = {30'd0, irqen};
            default:  PRDATA = 32'hDEADBEEF;
        endcase
    end

    assign PREADY = 1'b1;
    assign IRQ    = (ov & irqen[0]) | (early & irqen[1]);
    assign WDRST  = wdrst_q;
    assign WDRUN  = en;

endmodule
